id_issue_scoreboard: RTL and testbench
======================================

Name: id_issue_scoreboard

Overview:
- Parametrised next-generation decode/issue stage. Sits between the IF/ID register and EX.
- Replaces fixed rd-compare hazard detection with a per-register pending-write scoreboard, a valid/ready handshake on both sides, and a registered ID/EX output slot.
- Supports branch/call flush, a configurable in-flight limit, and a saturating stall-cycle counter for performance monitoring.

Parameters:
- DATA_W, 16, width of PC and sign-extended immediate.
- NUM_REGS, 16, architectural register count; REG_AW = $clog2(NUM_REGS).
- MAX_INFLIGHT, 3, maximum issued-but-not-written-back writers; CNT_W = $clog2(MAX_INFLIGHT+1).
- R0_HARDWIRED, 0, when 1, register 0 is never tracked and never causes a hazard.
- STALL_W, 16, width of the stall counter.

Ports:
- clk  in  1  global clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  IF/ID holds an instruction
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready
- in_opcode  in  4  Inst[15:12]
- in_rs  in  REG_AW  source 1
- in_rt  in  REG_AW  source 2
- in_rd  in  REG_AW  destination
- in_uses_rs  in  1  rs is read
- in_uses_rt  in  1  rt is read
- in_we  in  1  instruction writes rd
- in_imm  in  8  raw immediate
- in_imm_sel  in  1  0 = 4-bit arithmetic imm (in_imm[3:0]); 1 = 8-bit load/save imm
- in_pc  in  DATA_W  PC of the instruction
- out_valid  out  1  ID/EX slot is valid
- out_ready  in  1  EX accepts the slot
- out_opcode, out_rs, out_rt, out_rd, out_we, out_pc  out  as inputs  registered copies
- out_imm  out  DATA_W  sign-extended immediate
- wb_valid  in  1  writeback retiring a writer
- wb_rd  in  REG_AW  writeback register
- flush  in  1  kill the instruction in the ID/EX slot and block acceptance
- hazard  out  1  RAW stall this cycle
- stall_cnt  out  STALL_W  saturating count of cycles with in_valid && !in_ready

Behaviour:
- Reset (asynchronous, rst_n low):
  - out_valid = 0.
  - All out_* payload = 0.
  - All scoreboard counts = 0; inflight = 0.
  - stall_cnt = 0.
  - hazard and in_ready derive combinationally from reset state, so in_ready = 1 and hazard = 0.
- Tracking: a register is tracked unless R0_HARDWIRED && reg == 0.
- hazard (combinational) = in_valid && ((in_uses_rs && cnt[in_rs] != 0) || (in_uses_rt && cnt[in_rt] != 0)), tracked registers only.
  - No same-cycle bypass: a wb to rs in the same cycle still stalls; the hazard clears the following cycle.
- full = (inflight == MAX_INFLIGHT).
- in_ready = (!out_valid || out_ready) && !hazard && !full && !flush.
- accept = in_valid && in_ready. Latency is 1: the ID/EX slot loads on the next edge.
- out_fire = out_valid && out_ready && !flush. EX must qualify its handshake with !flush; flush wins.
- Slot update, in priority order:
  - flush: out_valid <= 0.
  - else accept: load payload, out_valid <= 1.
  - else out_fire: out_valid <= 0.
  - else: hold. Payload is stable while out_valid && !out_ready.
- Scoreboard increments and decrements:
  - inc: accept && in_we && tracked(in_rd), applied to cnt[in_rd].
  - dec_wb: wb_valid && tracked(wb_rd), applied to cnt[wb_rd].
  - dec_fl: flush && out_valid && out_we && tracked(out_rd), applied to cnt[out_rd].
  - Per register, net change = inc - dec_wb - dec_fl, all applied the same cycle. inc and dec on the same register gives net 0. Two decrements on the same register gives -2.
  - inflight uses the same net change, summed over all registers.
- Underflow (dec on a zero count) and overflow: the count and inflight saturate. Simulation-only assertion fires.
- stall_cnt increments when in_valid && !in_ready and saturates at all ones.
- Sign extension:
  - in_imm_sel = 0: out_imm = {{DATA_W-4}{imm[3]}, imm[3:0]}.
  - in_imm_sel = 1: out_imm = {{DATA_W-8}{imm[7]}, imm[7:0]}.
- Reset mid-operation: all state clears immediately. Pending writebacks arriving after reset are treated as underflow and saturate at 0.

Decomposition:
- Package id_issue_pkg:
  - OPC_W = 4.
  - issue_pkt_t struct with fields opcode, rs, rt, rd, we, imm, pc. Widths come from package localparams matching the defaults.
  - sext helper function.
- Sub-module id_scoreboard (parameters NUM_REGS, MAX_INFLIGHT, R0_HARDWIRED):
  - Holds the counter array and inflight count.
  - Inputs: inc/dec strobes with their register indices.
  - Outputs: busy_rs, busy_rt, full.
- Top level holds the handshake, the slot register, sign extension and stall_cnt.

Test Plan:
- Write then dependent read:
  - Stimulus: issue r3 write (in_we = 1, rd = 3); next cycle an instruction reading rs = 3.
  - Required: hazard = 1 and in_ready = 0 until wb_valid with wb_rd = 3. Accepted on the cycle after wb. stall_cnt counts the stalled cycles.
- In-flight limit:
  - Stimulus: issue 3 independent writers (r1, r2, r4) with out_ready = 1 and no wb.
  - Required: 4th instruction blocked (full). wb_rd = 1 leads to acceptance next cycle.
- Backpressure:
  - Stimulus: out_ready = 0 with the slot valid at pc = 0x0040.
  - Required: payload held; in_ready = 0; on out_ready = 1 the next instruction loads the following cycle.
- Flush with pending writer:
  - Stimulus: slot holds a write to r5; flush pulses.
  - Required: out_valid = 0 next cycle; cnt[5] returns to 0. A later read of r5 does not stall.
- Simultaneous events on r7:
  - Stimulus: accept a write to r7 while wb_rd = 7 in the same cycle.
  - Required: cnt[7] unchanged at 1.
- Sign extension and R0:
  - Sign extension: in_imm = 0x0F with sel = 0 gives out_imm = 0xFFFF. in_imm = 0x80 with sel = 1 gives 0xFF80.
  - R0: with R0_HARDWIRED = 1, a write to r0 followed by a read of r0 gives hazard = 0.

Source files
------------

// File: rtl/id_issue_pkg.sv
// id_issue_pkg: shared widths, the issue packet layout and the immediate
// sign-extension helper for the decode/issue stage.
//   OPC_W      opcode width (Inst[15:12])
//   IMM_W      raw immediate width at the IF/ID boundary
//   PKT_*      default datapath/register-address widths of an issue packet
package id_issue_pkg;

  localparam int OPC_W      = 4;
  localparam int IMM_W      = 8;
  localparam int PKT_DATA_W = 16;
  localparam int PKT_REG_AW = 4;

  typedef struct packed {
    logic [OPC_W-1:0]      opcode;
    logic [PKT_REG_AW-1:0] rs;
    logic [PKT_REG_AW-1:0] rt;
    logic [PKT_REG_AW-1:0] rd;
    logic                  we;
    logic [PKT_DATA_W-1:0] imm;
    logic [PKT_DATA_W-1:0] pc;
  } issue_pkt_t;

  // sel = 0: 4-bit arithmetic immediate; sel = 1: 8-bit load/save immediate.
  function automatic logic [PKT_DATA_W-1:0] sext(input logic [IMM_W-1:0] imm,
                                                 input logic             sel);
    if (sel) return {{(PKT_DATA_W-8){imm[7]}}, imm};
    return {{(PKT_DATA_W-4){imm[3]}}, imm[3:0]};
  endfunction

endpackage

// File: rtl/id_scoreboard.sv
// id_scoreboard: per-register pending-write counters plus a total in-flight
// count. A register's counter is the number of issued writers to it that
// have not yet written back (or been flushed).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   inc, inc_rd       one writer issued to inc_rd
//   dec_wb, wb_rd     one writer to wb_rd written back
//   dec_fl, fl_rd     one writer to fl_rd killed by flush
//   rs, rt            source registers being queried
//   busy_rs, busy_rt  source has a pending writer (tracked registers only)
//   full              in-flight count has reached MAX_INFLIGHT
module id_scoreboard #(
  parameter  int NUM_REGS     = 16,
  parameter  int MAX_INFLIGHT = 3,
  parameter  int R0_HARDWIRED = 0,
  localparam int REG_AW       = $clog2(NUM_REGS),
  localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic [REG_AW-1:0] inc_rd,
  input  logic              dec_wb,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              dec_fl,
  input  logic [REG_AW-1:0] fl_rd,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  output logic              busy_rs,
  output logic              busy_rt,
  output logic              full
);

  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic [CNT_W-1:0]    inflight_q;
  logic [CNT_W-1:0]    inflight_d;
  logic [NUM_REGS-1:0] uflow;
  logic [NUM_REGS-1:0] oflow;

  function automatic logic tracked(input logic [REG_AW-1:0] r);
    return !(R0_HARDWIRED != 0 && r == '0);
  endfunction

  // All strobes land in the same cycle; a register can see +1, -1 and -1
  // together. Results clamp to [0, MAX_INFLIGHT]. inflight is rebuilt from
  // the clamped counts so it can never disagree with the array.
  always_comb begin
    int net;
    int total;
    net   = 0;
    total = 0;
    uflow = '0;
    oflow = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      net = int'(cnt_q[i]);
      if (inc    && tracked(inc_rd) && inc_rd == REG_AW'(i)) net = net + 1;
      if (dec_wb && tracked(wb_rd)  && wb_rd  == REG_AW'(i)) net = net - 1;
      if (dec_fl && tracked(fl_rd)  && fl_rd  == REG_AW'(i)) net = net - 1;
      uflow[i] = (net < 0);
      oflow[i] = (net > MAX_INFLIGHT);
      if (net < 0)                 net = 0;
      else if (net > MAX_INFLIGHT) net = MAX_INFLIGHT;
      cnt_d[i] = CNT_W'(net);
      total    = total + net;
    end
    if (total > MAX_INFLIGHT) total = MAX_INFLIGHT;
    inflight_d = CNT_W'(total);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
      inflight_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= cnt_d[i];
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (uflow == '0) else $error("id_scoreboard: count underflow %h", uflow);
      assert (oflow == '0) else $error("id_scoreboard: count overflow %h", oflow);
    end
  end

  assign busy_rs = tracked(rs) && (cnt_q[rs] != '0);
  assign busy_rt = tracked(rt) && (cnt_q[rt] != '0);
  assign full    = (inflight_q == CNT_W'(MAX_INFLIGHT));

endmodule

// File: rtl/id_issue_scoreboard.sv
// id_issue_scoreboard: decode/issue stage between IF/ID and EX. Stalls on
// RAW hazards using a pending-write scoreboard, limits in-flight writers,
// and holds the issued instruction in a registered ID/EX slot.
// Handshakes: a transfer happens on a cycle where valid && ready at the
// rising edge. in_valid/in_ready move IF/ID into the slot (one cycle later
// the slot shows it); out_valid/out_ready move the slot into EX, and EX
// must additionally treat flush as cancelling that transfer. While
// out_valid && !out_ready the slot payload does not change.
// Ports:
//   in_*        instruction from IF/ID, in_ready back-pressure
//   out_*       registered ID/EX slot, out_imm sign-extended to DATA_W
//   wb_valid/wb_rd  writeback retiring a writer
//   flush       kills the slot contents and blocks acceptance this cycle
//   hazard      RAW stall this cycle
//   stall_cnt   saturating count of cycles with in_valid && !in_ready
module id_issue_scoreboard
  import id_issue_pkg::*;
#(
  parameter  int DATA_W       = 16,
  parameter  int NUM_REGS     = 16,
  parameter  int MAX_INFLIGHT = 3,
  parameter  int R0_HARDWIRED = 0,
  parameter  int STALL_W      = 16,
  localparam int REG_AW       = $clog2(NUM_REGS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OPC_W-1:0]   in_opcode,
  input  logic [REG_AW-1:0]  in_rs,
  input  logic [REG_AW-1:0]  in_rt,
  input  logic [REG_AW-1:0]  in_rd,
  input  logic               in_uses_rs,
  input  logic               in_uses_rt,
  input  logic               in_we,
  input  logic [IMM_W-1:0]   in_imm,
  input  logic               in_imm_sel,
  input  logic [DATA_W-1:0]  in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPC_W-1:0]   out_opcode,
  output logic [REG_AW-1:0]  out_rs,
  output logic [REG_AW-1:0]  out_rt,
  output logic [REG_AW-1:0]  out_rd,
  output logic               out_we,
  output logic [DATA_W-1:0]  out_imm,
  output logic [DATA_W-1:0]  out_pc,
  input  logic               wb_valid,
  input  logic [REG_AW-1:0]  wb_rd,
  input  logic               flush,
  output logic               hazard,
  output logic [STALL_W-1:0] stall_cnt
);

  logic              busy_rs;
  logic              busy_rt;
  logic              full;
  logic              accept;
  logic              out_fire;
  logic [DATA_W-1:0] imm_ext;

  id_scoreboard #(
    .NUM_REGS     (NUM_REGS),
    .MAX_INFLIGHT (MAX_INFLIGHT),
    .R0_HARDWIRED (R0_HARDWIRED)
  ) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (accept && in_we),
    .inc_rd  (in_rd),
    .dec_wb  (wb_valid),
    .wb_rd   (wb_rd),
    .dec_fl  (flush && out_valid && out_we),
    .fl_rd   (out_rd),
    .rs      (in_rs),
    .rt      (in_rt),
    .busy_rs (busy_rs),
    .busy_rt (busy_rt),
    .full    (full)
  );

  always_comb begin
    if (in_imm_sel) imm_ext = {{(DATA_W-8){in_imm[7]}}, in_imm};
    else            imm_ext = {{(DATA_W-4){in_imm[3]}}, in_imm[3:0]};
  end

  // No writeback bypass: a register retiring this cycle still reads busy.
  assign hazard   = in_valid && ((in_uses_rs && busy_rs) || (in_uses_rt && busy_rt));
  assign in_ready = (!out_valid || out_ready) && !hazard && !full && !flush;
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready && !flush;

  // Slot priority: flush kills, then a new accept (which may replace a
  // firing entry), then a plain fire empties, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_opcode <= '0;
      out_rs     <= '0;
      out_rt     <= '0;
      out_rd     <= '0;
      out_we     <= 1'b0;
      out_imm    <= '0;
      out_pc     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_opcode <= in_opcode;
      out_rs     <= in_rs;
      out_rt     <= in_rt;
      out_rd     <= in_rd;
      out_we     <= in_we;
      out_imm    <= imm_ext;
      out_pc     <= in_pc;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

endmodule

// File: tb/tb_id_issue_scoreboard.sv
module tb_id_issue_scoreboard;

  localparam int PKT_W = 49;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, in_uses_rs, in_uses_rt, in_we, in_imm_sel;
  logic [3:0]  in_opcode, in_rs, in_rt, in_rd;
  logic [7:0]  in_imm;
  logic [15:0] in_pc;
  logic        out_valid, out_ready, out_we;
  logic [3:0]  out_opcode, out_rs, out_rt, out_rd;
  logic [15:0] out_imm, out_pc;
  logic        wb_valid, flush, hazard;
  logic [3:0]  wb_rd;
  logic [15:0] stall_cnt;

  // second instance with register 0 hardwired
  logic        in_valid_h, wb_valid_h, in_ready_h, out_valid_h, out_we_h, hazard_h;
  logic [3:0]  out_opcode_h, out_rs_h, out_rt_h, out_rd_h;
  logic [15:0] out_imm_h, out_pc_h, stall_cnt_h;

  id_issue_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_uses_rs(in_uses_rs), .in_uses_rt(in_uses_rt), .in_we(in_we),
    .in_imm(in_imm), .in_imm_sel(in_imm_sel), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_we(out_we),
    .out_imm(out_imm), .out_pc(out_pc), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .flush(flush), .hazard(hazard), .stall_cnt(stall_cnt)
  );

  id_issue_scoreboard #(.R0_HARDWIRED(1)) dut_h (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_h), .in_ready(in_ready_h),
    .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_uses_rs(in_uses_rs), .in_uses_rt(in_uses_rt), .in_we(in_we),
    .in_imm(in_imm), .in_imm_sel(in_imm_sel), .in_pc(in_pc),
    .out_valid(out_valid_h), .out_ready(out_ready), .out_opcode(out_opcode_h),
    .out_rs(out_rs_h), .out_rt(out_rt_h), .out_rd(out_rd_h), .out_we(out_we_h),
    .out_imm(out_imm_h), .out_pc(out_pc_h), .wb_valid(wb_valid_h), .wb_rd(wb_rd),
    .flush(flush), .hazard(hazard_h), .stall_cnt(stall_cnt_h)
  );

  // ---------------- scoreboard / reference model ----------------
  int errors = 0;
  int checks = 0;
  logic [PKT_W-1:0] exp_q[$];   // expected ID/EX slot contents (0 or 1 entry)
  logic [3:0]       pend_q[$];  // writers that reached EX and await writeback
  int               m_cnt[16];  // outstanding writers per register
  int               m_stall;
  logic             s_hazard, s_ready, s_hazard_h;

  logic [PKT_W-1:0] dut_pkt;
  assign dut_pkt = {out_opcode, out_rs, out_rt, out_rd, out_we, out_imm, out_pc};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_sext(input logic [7:0] imm, input logic sel);
    logic [3:0] lo;
    int v;
    lo = imm[3:0];
    if (sel) v = int'($signed(imm));
    else     v = int'($signed(lo));
    return v[15:0];
  endfunction

  function automatic logic [PKT_W-1:0] cur_pkt();
    return {in_opcode, in_rs, in_rt, in_rd, in_we, ref_sext(in_imm, in_imm_sel), in_pc};
  endfunction

  function automatic int m_sum();
    int s = 0;
    for (int i = 0; i < 16; i++) s += m_cnt[i];
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [3:0] opc, input logic [3:0] rs, input logic [3:0] rt,
                       input logic [3:0] rd, input logic urs, input logic urt, input logic we,
                       input logic [7:0] imm, input logic sel, input logic [15:0] pc);
    in_valid = 1'b1; in_opcode = opc; in_rs = rs; in_rt = rt; in_rd = rd;
    in_uses_rs = urs; in_uses_rt = urt; in_we = we;
    in_imm = imm; in_imm_sel = sel; in_pc = pc;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_valid_h = 1'b0; wb_valid = 1'b0; wb_valid_h = 1'b0;
    flush = 1'b0; wb_rd = 4'd0;
    in_opcode = 4'd0; in_rs = 4'd0; in_rt = 4'd0; in_rd = 4'd0;
    in_uses_rs = 1'b0; in_uses_rt = 1'b0; in_we = 1'b0;
    in_imm = 8'd0; in_imm_sel = 1'b0; in_pc = 16'd0;
  endtask

  // One clock: check combinational outputs at the falling edge against the
  // model, advance the model, then check registered outputs after the edge.
  task automatic step();
    logic ov, e_haz, e_rdy, acc, fire;
    logic [PKT_W-1:0] slot;
    @(negedge clk);
    ov    = (exp_q.size() != 0);
    slot  = ov ? exp_q[0] : '0;
    e_haz = in_valid && ((in_uses_rs && m_cnt[in_rs] != 0) || (in_uses_rt && m_cnt[in_rt] != 0));
    e_rdy = (!ov || out_ready) && !e_haz && (m_sum() < 3) && !flush;
    s_hazard = hazard; s_ready = in_ready; s_hazard_h = hazard_h;
    chk("hazard", hazard, e_haz);
    chk("in_ready", in_ready, e_rdy);
    acc  = in_valid && e_rdy;
    fire = ov && out_ready && !flush;
    if (in_valid && !e_rdy && m_stall < 65535) m_stall++;
    if (acc && in_we) m_cnt[in_rd]++;
    if (wb_valid) begin
      m_cnt[wb_rd]--;
      for (int i = 0; i < pend_q.size(); i++)
        if (pend_q[i] == wb_rd) begin pend_q.delete(i); break; end
    end
    if (flush && ov && slot[32]) m_cnt[slot[36:33]]--;
    if (fire && slot[32]) pend_q.push_back(slot[36:33]);
    if (flush) exp_q.delete();
    else begin
      if (fire) void'(exp_q.pop_front());
      if (acc)  exp_q.push_back(cur_pkt());
    end
    @(posedge clk); #1;
    chk("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) chk("payload", dut_pkt, exp_q[0]);
    chk("stall_cnt", stall_cnt, 64'(m_stall));
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear at once.
  task automatic do_reset();
    idle();
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_payload", dut_pkt, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_hazard", hazard, 0);
    exp_q.delete(); pend_q.delete();
    for (int i = 0; i < 16; i++) m_cnt[i] = 0;
    m_stall = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    idle();
    out_ready = 1'b1;
    m_stall = 0;
    for (int i = 0; i < 16; i++) m_cnt[i] = 0;

    // write r3, then dependent read stalls until writeback
    do_reset();
    drive(4'h1, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 16'h0010); step();
    drive(4'h2, 4'd3, 4'd0, 4'd8, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0012); step();
    chk("raw_hazard", s_hazard, 1);
    chk("raw_stall", s_ready, 0);
    wb_valid = 1'b1; wb_rd = 4'd3; step();
    chk("raw_no_bypass", s_hazard, 1);
    wb_valid = 1'b0; step();
    chk("raw_accept", s_ready, 1);
    chk("raw_stall_cnt", stall_cnt, 2);
    idle(); step();

    // in-flight limit
    do_reset();
    drive(4'h3, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 16'h0100); step();
    drive(4'h3, 4'd0, 4'd0, 4'd2, 1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 16'h0102); step();
    drive(4'h3, 4'd0, 4'd0, 4'd4, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 16'h0104); step();
    chk("lim_third_ok", s_ready, 1);
    drive(4'h3, 4'd0, 4'd0, 4'd6, 1'b0, 1'b0, 1'b1, 8'h04, 1'b0, 16'h0106); step();
    chk("lim_full", s_ready, 0);
    wb_valid = 1'b1; wb_rd = 4'd1; step();
    chk("lim_full_wb_cycle", s_ready, 0);
    wb_valid = 1'b0; step();
    chk("lim_accept_after_wb", s_ready, 1);
    idle(); step();

    // backpressure holds payload
    do_reset();
    out_ready = 1'b0;
    drive(4'h4, 4'd1, 4'd2, 4'd9, 1'b1, 1'b1, 1'b0, 8'h11, 1'b1, 16'h0040); step();
    drive(4'h5, 4'd1, 4'd2, 4'd9, 1'b1, 1'b1, 1'b0, 8'h22, 1'b1, 16'h0044);
    repeat (2) begin
      step();
      chk("bp_blocked", s_ready, 0);
      chk("bp_hold_pc", out_pc, 16'h0040);
    end
    out_ready = 1'b1; step();
    chk("bp_release", s_ready, 1);
    chk("bp_next_pc", out_pc, 16'h0044);
    idle(); step();

    // flush of a pending writer
    do_reset();
    out_ready = 1'b0;
    drive(4'h6, 4'd0, 4'd0, 4'd5, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 16'h0050); step();
    idle(); flush = 1'b1; step();
    chk("fl_slot_killed", out_valid, 0);
    flush = 1'b0;
    drive(4'h7, 4'd5, 4'd5, 4'd10, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0052); step();
    chk("fl_no_hazard", s_hazard, 0);
    chk("fl_accept", s_ready, 1);
    out_ready = 1'b1; idle(); step();

    // accept a write to r7 while r7 writes back
    do_reset();
    drive(4'h8, 4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 16'h0070); step();
    idle(); step();
    drive(4'h8, 4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 16'h0072);
    wb_valid = 1'b1; wb_rd = 4'd7; step();
    chk("r7_accept", s_ready, 1);
    wb_valid = 1'b0;
    drive(4'h9, 4'd7, 4'd0, 4'd11, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0074); step();
    chk("r7_still_pending", s_hazard, 1);
    wb_valid = 1'b1; wb_rd = 4'd7; step();
    wb_valid = 1'b0; step();
    chk("r7_count_was_one", s_hazard, 0);
    idle(); step();

    // sign extension
    do_reset();
    drive(4'hA, 4'd0, 4'd0, 4'd12, 1'b0, 1'b0, 1'b0, 8'h0F, 1'b0, 16'h0080); step();
    chk("sext4_neg", out_imm, 16'hFFFF);
    drive(4'hA, 4'd0, 4'd0, 4'd12, 1'b0, 1'b0, 1'b0, 8'h80, 1'b1, 16'h0082); step();
    chk("sext8_neg", out_imm, 16'hFF80);
    drive(4'hA, 4'd0, 4'd0, 4'd12, 1'b0, 1'b0, 1'b0, 8'hF7, 1'b0, 16'h0084); step();
    chk("sext4_pos", out_imm, 16'h0007);
    drive(4'hA, 4'd0, 4'd0, 4'd12, 1'b0, 1'b0, 1'b0, 8'h7F, 1'b1, 16'h0086); step();
    chk("sext8_pos", out_imm, 16'h007F);
    idle(); step();

    // register 0: tracked in dut, hardwired in dut_h
    do_reset();
    drive(4'hB, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 16'h0090);
    in_valid_h = 1'b1; step();
    drive(4'hC, 4'd0, 4'd0, 4'd13, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0092);
    in_valid_h = 1'b1; step();
    chk("r0_hardwired_no_hazard", s_hazard_h, 0);
    chk("r0_tracked_hazard", s_hazard, 1);
    in_valid_h = 1'b0;
    wb_valid = 1'b1; wb_rd = 4'd0; step();
    wb_valid = 1'b0; step();
    idle(); step();

    // randomized traffic with a reset in the middle
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c == 300) do_reset();
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
            16'($urandom_range(0, 65535)));
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      wb_valid  = 1'b0;
      if (pend_q.size() != 0 && $urandom_range(0, 2) != 0) begin
        wb_valid = 1'b1;
        wb_rd    = pend_q[$urandom_range(0, pend_q.size() - 1)];
      end
      step();
    end
    idle(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
